// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch-to-decode FIFO with flush and fault-lock.
module instr_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            ld_valid_i,
    output logic            ld_ready_o,
    input  logic [XLEN-1:0] ld_pc_i,
    input  logic [ILEN-1:0] ld_instr_i,
    input  logic            ld_fault_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [XLEN-1:0] dec_pc_o,
    output logic [ILEN-1:0] dec_instr_o,
    output logic            dec_fault_o,
    output logic [CW-1:0]   count_o,
    output logic            fault_lock_o,
    output logic            busy_o
);
    localparam int AW = $clog2(DEPTH);
    logic [XLEN-1:0] pc_mem [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];
    logic            fault_mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            fault_lock_q, fault_lock_d;
    logic            push, pop;
    always_comb begin
        ld_ready_o   = (count_q != CW'(DEPTH)) && !fault_lock_q && !flush_i;
        dec_valid_o  = (count_q != '0) && !flush_i;
        push         = ld_valid_i && ld_ready_o;
        pop          = dec_valid_o && dec_ready_i;
        wr_ptr_d     = flush_i ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d     = flush_i ? '0 : rd_ptr_q + AW'(pop);
        count_d      = flush_i ? '0 : count_q + CW'(push) - CW'(pop);
        fault_lock_d = flush_i ? 1'b0 : (fault_lock_q || (push && ld_fault_i));
        dec_pc_o     = dec_valid_o ? pc_mem[rd_ptr_q] : '0;
        dec_instr_o  = dec_valid_o ? instr_mem[rd_ptr_q] : '0;
        dec_fault_o  = dec_valid_o ? fault_mem[rd_ptr_q] : 1'b0;
        count_o      = count_q;
        fault_lock_o = fault_lock_q;
        busy_o       = count_q != '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fault_lock_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fault_lock_q <= fault_lock_d;
        end
    end
    // Storage is never reset; outputs are masked by dec_valid_o instead.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= ld_pc_i;
            instr_mem[wr_ptr_q] <= ld_instr_i;
            fault_mem[wr_ptr_q] <= ld_fault_i;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= CW'(DEPTH));
            assert (AW'(wr_ptr_q - rd_ptr_q) == count_q[AW-1:0]);
            assert (!(push && fault_lock_q));
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed and random checks against a queue model.
module tb_instr_fetch_queue;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH + 1);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_i = 1'b0;
    logic          ld_valid_i = 1'b0;
    logic          ld_ready_o;
    logic [31:0]   ld_pc_i = '0;
    logic [31:0]   ld_instr_i = '0;
    logic          ld_fault_i = 1'b0;
    logic          dec_valid_o;
    logic          dec_ready_i = 1'b0;
    logic [31:0]   dec_pc_o;
    logic [31:0]   dec_instr_o;
    logic          dec_fault_o;
    logic [CW-1:0] count_o;
    logic          fault_lock_o;
    logic          busy_o;
    int checks = 0;
    int errors = 0;
    ent_t q[$];
    logic m_lock = 1'b0;
    logic armed = 1'b0;
    logic        s_ready, s_valid, s_lock, s_busy, s_fault;
    logic [31:0] s_pc;
    logic [CW-1:0] s_count;

    instr_fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .ILEN(32)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_pc_i(ld_pc_i),
        .ld_instr_i(ld_instr_i), .ld_fault_i(ld_fault_i),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i), .dec_pc_o(dec_pc_o),
        .dec_instr_o(dec_instr_o), .dec_fault_o(dec_fault_o), .count_o(count_o),
        .fault_lock_o(fault_lock_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare against the model, then advance the model.
    task automatic cyc(input logic r, input logic f, input logic v, input logic [31:0] pc,
                       input logic flt, input logic dr);
        logic ev, er;
        ent_t head, e;
        @(negedge clk);
        rst = r; flush_i = f; ld_valid_i = v; ld_pc_i = pc;
        ld_instr_i = $urandom; ld_fault_i = flt; dec_ready_i = dr;
        #1;
        s_ready = ld_ready_o; s_valid = dec_valid_o; s_lock = fault_lock_o;
        s_busy = busy_o; s_pc = dec_pc_o; s_fault = dec_fault_o; s_count = count_o;
        er = (q.size() != DEPTH) && !m_lock && !f;
        ev = (q.size() != 0) && !f;
        head = ev ? q[0] : '0;
        if (armed) begin
            check("ld_ready", 64'(ld_ready_o), 64'(er));
            check("dec_valid", 64'(dec_valid_o), 64'(ev));
            check("count", 64'(count_o), 64'(q.size()));
            check("busy", 64'(busy_o), 64'(q.size() != 0));
            check("fault_lock", 64'(fault_lock_o), 64'(m_lock));
            check("dec_pc", 64'(dec_pc_o), 64'(head.pc));
            check("dec_instr", 64'(dec_instr_o), 64'(head.instr));
            check("dec_fault", 64'(dec_fault_o), 64'(head.fault));
        end
        if (r || f) begin
            q.delete();
            m_lock = 1'b0;
        end else begin
            if (ev && dr) void'(q.pop_front());
            if (v && er) begin
                e.pc = pc; e.instr = ld_instr_i; e.fault = flt;
                q.push_back(e);
                if (flt) m_lock = 1'b1;
            end
        end
        if (r) armed = 1'b1;
    endtask

    task automatic idle(input logic v, input logic dr);
        cyc(1'b0, 1'b0, v, 32'h0, 1'b0, dr);
    endtask

    task automatic push(input logic [31:0] pc, input logic flt);
        cyc(1'b0, 1'b0, 1'b1, pc, flt, 1'b0);
    endtask

    initial begin
        // Reset
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(0, 0);
        check("pin_rst_ready", 64'(s_ready), 64'd1);
        check("pin_rst_valid", 64'(s_valid), 64'd0);
        check("pin_rst_count", 64'(s_count), 64'd0);
        // Fill then drain
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 0);
        idle(0, 0);
        check("pin_full_count", 64'(s_count), 64'd4);
        check("pin_full_ready", 64'(s_ready), 64'd0);
        check("pin_full_pc", 64'(s_pc), 64'h100);
        check("pin_model_size", 64'(q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            idle(0, 1);
            check("pin_drain_pc", 64'(s_pc), 64'(32'h100 + 32'(4 * i)));
        end
        idle(0, 0);
        check("pin_empty_count", 64'(s_count), 64'd0);
        check("pin_empty_valid", 64'(s_valid), 64'd0);
        // Streaming across pointer wrap
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 1, 32'h400 + 32'(4 * i), 0, 1);
            if (i == 0) check("pin_stream_first", 64'(s_valid), 64'd0);
            else begin
                check("pin_stream_count", 64'(s_count), 64'd1);
                check("pin_stream_pc", 64'(s_pc), 64'(32'h400 + 32'(4 * (i - 1))));
            end
        end
        idle(0, 1);
        // Flush with handshakes offered
        for (int i = 0; i < 3; i++) push(32'h180 + 32'(4 * i), 0);
        cyc(0, 1, 1, 32'h1ff, 0, 1);
        check("pin_flush_ready", 64'(s_ready), 64'd0);
        check("pin_flush_valid", 64'(s_valid), 64'd0);
        idle(0, 0);
        check("pin_postflush_count", 64'(s_count), 64'd0);
        check("pin_postflush_ready", 64'(s_ready), 64'd1);
        push(32'h200, 0);
        idle(0, 0);
        check("pin_postflush_head", 64'(s_pc), 64'h200);
        idle(0, 1);
        // Fault lock
        push(32'h300, 0);
        push(32'h304, 1);
        push(32'h308, 0);
        check("pin_fault_ready", 64'(s_ready), 64'd0);
        check("pin_fault_lock", 64'(s_lock), 64'd1);
        idle(0, 1);
        check("pin_fault_pc0", 64'(s_pc), 64'h300);
        check("pin_fault_f0", 64'(s_fault), 64'd0);
        idle(0, 1);
        check("pin_fault_pc1", 64'(s_pc), 64'h304);
        check("pin_fault_f1", 64'(s_fault), 64'd1);
        idle(1, 0);
        check("pin_locked_count", 64'(s_count), 64'd0);
        check("pin_locked_ready", 64'(s_ready), 64'd0);
        cyc(0, 1, 0, 0, 0, 0);
        idle(0, 0);
        check("pin_unlock_lock", 64'(s_lock), 64'd0);
        check("pin_unlock_ready", 64'(s_ready), 64'd1);
        // Full with simultaneous offer and pop
        for (int i = 0; i < 4; i++) push(32'h500 + 32'(4 * i), 0);
        cyc(0, 0, 1, 32'h510, 0, 1);
        idle(0, 0);
        check("pin_fullpop_count", 64'(s_count), 64'd3);
        check("pin_fullpop_ready", 64'(s_ready), 64'd1);
        cyc(0, 1, 0, 0, 0, 0);
        // Reset mid-stream with lock set
        push(32'h600, 0);
        push(32'h604, 1);
        cyc(1, 0, 1, 32'h608, 0, 1);
        idle(0, 0);
        check("pin_midrst_count", 64'(s_count), 64'd0);
        check("pin_midrst_pc", 64'(s_pc), 64'd0);
        check("pin_midrst_lock", 64'(s_lock), 64'd0);
        check("pin_midrst_busy", 64'(s_busy), 64'd0);
        check("pin_midrst_ready", 64'(s_ready), 64'd1);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 3) != 0), $urandom,
                ($urandom_range(0, 24) == 0), ($urandom_range(0, 2) != 0));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
